// File: rtl/pipeline_mips_pkg.sv
// Shared types and constants for the 16-bit pipelined MIPS front end.
package pipeline_mips_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INS_W  = 16;

    localparam logic [INS_W-1:0]  NOP_INS_DEFAULT  = 16'h0000;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } if_id_t;

    // True when addr names an existing instruction word
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned        depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Increment on enable until the ceiling is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, addresses the synchronous instruction
// memory and loads IF/ID with stall, redirect, halt and range-fault handling.
module imem_fetch_ctrl
    import pipeline_mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned       PC_STEP   = 1,
    parameter int unsigned       MEM_DEPTH = 65536,
    parameter logic [INS_W-1:0]  NOP_INS   = NOP_INS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [INS_W-1:0]  imem_ins,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INS_W-1:0]  if_id_ins,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic              addr_fault,
    output logic [15:0]       fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] seq_pc;
    if_id_t            if_id_q;

    // Decoded per-cycle actions
    logic advance;      // deliver imem_ins/pc_q into IF/ID
    logic flush;        // redirect: invalidate IF/ID and load NOP
    logic drop;         // halt or sequential fault: invalidate IF/ID
    logic fault_set;    // next_pc would have left the memory

    // Memory and pc_q sample the same address on every edge
    assign imem_address = next_pc;

    // Next-state, next-PC and IF/ID action selection
    always_comb begin
        state_nx  = state;
        next_pc   = pc_q;
        seq_pc    = pc_q + ADDR_W'(PC_STEP);
        advance   = 1'b0;
        flush     = 1'b0;
        drop      = 1'b0;
        fault_set = 1'b0;

        unique case (state)
            BOOT: begin
                next_pc  = RESET_PC;
                state_nx = RUN;
            end
            RUN, HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (addr_in_range(redirect_pc, MEM_DEPTH)) begin
                        next_pc  = redirect_pc;
                        state_nx = RUN;
                    end else begin
                        fault_set = 1'b1;
                        state_nx  = HALT;
                    end
                end else if (state == RUN) begin
                    if (halt_req) begin
                        drop     = 1'b1;
                        state_nx = HALT;
                    end else if (!stall) begin
                        if (addr_in_range(seq_pc, MEM_DEPTH)) begin
                            advance = 1'b1;
                            next_pc = seq_pc;
                        end else begin
                            fault_set = 1'b1;
                            drop      = 1'b1;
                            state_nx  = HALT;
                        end
                    end
                end
            end
            default: begin
                next_pc  = RESET_PC;
                state_nx = BOOT;
            end
        endcase
    end

    // State, PC, IF/ID and status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            if_id_q    <= '{ins: NOP_INS, pc: '0, valid: 1'b0};
            halted     <= 1'b0;
            addr_fault <= 1'b0;
        end else begin
            state  <= state_nx;
            pc_q   <= next_pc;
            halted <= (state_nx == HALT);
            if (fault_set) begin
                addr_fault <= 1'b1;
            end
            if (advance) begin
                if_id_q <= '{ins: imem_ins, pc: pc_q, valid: 1'b1};
            end else if (flush) begin
                if_id_q.ins   <= NOP_INS;
                if_id_q.valid <= 1'b0;
            end else if (drop) begin
                if_id_q.valid <= 1'b0;
            end
        end
    end

    assign if_id_ins   = if_id_q.ins;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_valid = if_id_q.valid;

    // Count of instructions actually delivered to decode
    sat_counter16 u_fetch_count (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .count (fetch_count)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a full-depth and a 64-word instance
// share stimulus; each is compared against its own abstract fetch model.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam int unsigned DEPTH_F = 65536;
    localparam int unsigned DEPTH_S = 64;
    localparam logic [15:0] NOP     = 16'h0000;
    localparam logic [15:0] RST_PC  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;

    logic [15:0] addr_f, mem_f, ins_f, pc_f, cnt_f;
    logic        valid_f, halted_f, fault_f;
    logic [15:0] addr_s, mem_s, ins_s, pc_s, cnt_s;
    logic        valid_s, halted_s, fault_s;

    always #5 clk = ~clk;

    // Instruction memories preloaded with mem[i] = 16'h1000 + i
    always @(posedge clk) mem_f <= 16'h1000 + addr_f;
    always @(posedge clk) mem_s <= 16'h1000 + addr_s;

    imem_fetch_ctrl u_full (
        .clk(clk), .rst_n(rst_n), .imem_address(addr_f), .imem_ins(mem_f),
        .stall(stall), .halt_req(halt_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_ins(ins_f), .if_id_pc(pc_f),
        .if_id_valid(valid_f), .halted(halted_f), .addr_fault(fault_f),
        .fetch_count(cnt_f)
    );

    imem_fetch_ctrl #(.MEM_DEPTH(DEPTH_S)) u_small (
        .clk(clk), .rst_n(rst_n), .imem_address(addr_s), .imem_ins(mem_s),
        .stall(stall), .halt_req(halt_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_id_ins(ins_s), .if_id_pc(pc_s),
        .if_id_valid(valid_s), .halted(halted_s), .addr_fault(fault_s),
        .fetch_count(cnt_s)
    );

    typedef struct packed {
        logic        boot, halted, fault, valid;
        logic [15:0] pc, ins, ifpc, cnt;
    } mstate_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        valid;
        logic [15:0] ins, pc;
        logic        halted, fault;
        logic [15:0] cnt;
        logic        nop;
    } exp_t;

    typedef struct packed {
        exp_t f;
        exp_t s;
    } entry_t;

    entry_t  sb[$];
    mstate_t m_f, m_s;
    int      checks = 0;
    int      errors = 0;

    function automatic mstate_t model_reset();
        mstate_t m;
        m      = '0;
        m.boot = 1'b1;
        m.pc   = RST_PC;
        m.ins  = NOP;
        return m;
    endfunction

    // One clock of fetch behaviour, written from the fetch rules directly
    function automatic void step(inout mstate_t m, input int unsigned depth,
                                 input logic rv, input logic [15:0] rpc,
                                 input logic hr, input logic st, output exp_t e);
        logic [15:0] target;
        logic        nop;
        int unsigned nxt;
        target = m.pc;
        nop    = 1'b0;
        if (m.boot) begin
            m.boot = 1'b0;
            target = RST_PC;
        end else if (rv) begin
            m.valid = 1'b0;
            m.ins   = NOP;
            nop     = 1'b1;
            if (32'(rpc) < depth) begin
                target   = rpc;
                m.halted = 1'b0;
            end else begin
                m.fault  = 1'b1;
                m.halted = 1'b1;
            end
        end else if (m.halted) begin
            target = m.pc;
        end else if (hr) begin
            m.halted = 1'b1;
            m.valid  = 1'b0;
        end else if (!st) begin
            nxt = (32'(m.pc) + 1) % 65536;
            if (nxt < depth) begin
                m.valid = 1'b1;
                m.ins   = 16'h1000 + m.pc;
                m.ifpc  = m.pc;
                if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
                target  = 16'(nxt);
            end else begin
                m.fault  = 1'b1;
                m.halted = 1'b1;
                m.valid  = 1'b0;
            end
        end
        m.pc     = target;
        e.addr   = target;
        e.valid  = m.valid;
        e.ins    = m.ins;
        e.pc     = m.ifpc;
        e.halted = m.halted;
        e.fault  = m.fault;
        e.cnt    = m.cnt;
        e.nop    = nop;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the expected response of both DUTs
    task automatic cycle(input logic rv, input logic [15:0] rpc, input logic hr, input logic st);
        entry_t en;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        stall          = st;
        step(m_f, DEPTH_F, rv, rpc, hr, st, en.f);
        step(m_s, DEPTH_S, rv, rpc, hr, st, en.s);
        sb.push_back(en);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // Short asynchronous reset pulse between a rising and a falling edge
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        stall          = 1'b0;
        #1;
        check("rst.full.valid",  16'(valid_f),  16'h0);
        check("rst.full.count",  cnt_f,         16'h0);
        check("rst.full.addr",   addr_f,        RST_PC);
        check("rst.full.halted", 16'(halted_f), 16'h0);
        check("rst.full.fault",  16'(fault_f),  16'h0);
        check("rst.full.ins",    ins_f,         NOP);
        check("rst.small.valid", 16'(valid_s),  16'h0);
        check("rst.small.count", cnt_s,         16'h0);
        check("rst.small.addr",  addr_s,        RST_PC);
        check("rst.small.fault", 16'(fault_s),  16'h0);
        #1;
        rst_n = 1'b1;
        m_f   = model_reset();
        m_s   = model_reset();
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [15:0] a,
                       input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic h, input logic fl, input logic [15:0] c);
        check({tag, ".imem_address"}, a, e.addr);
        check({tag, ".if_id_valid"}, 16'(v), 16'(e.valid));
        check({tag, ".halted"}, 16'(h), 16'(e.halted));
        check({tag, ".addr_fault"}, 16'(fl), 16'(e.fault));
        check({tag, ".fetch_count"}, c, e.cnt);
        if (e.valid) begin
            check({tag, ".if_id_ins"}, ins, e.ins);
            check({tag, ".if_id_pc"}, pc, e.pc);
        end
        if (e.nop) check({tag, ".flush_ins"}, ins, NOP);
    endtask

    // Monitor: sample address before the edge, registers after, then compare
    initial begin
        entry_t      en;
        logic [15:0] a_f, a_s;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                a_f = addr_f;
                a_s = addr_s;
                @(posedge clk);
                #1;
                en = sb.pop_front();
                cmp("full",  en.f, a_f, valid_f, ins_f, pc_f, halted_f, fault_f, cnt_f);
                cmp("small", en.s, a_s, valid_s, ins_s, pc_s, halted_s, fault_s, cnt_s);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        m_f = model_reset();
        m_s = model_reset();
        repeat (2) @(posedge clk);
        pulse_reset();

        adv(4);                                           // boot + pcs 0,1,2
        repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b1);        // stall
        adv(3);
        cycle(1'b1, 16'h0040, 1'b0, 1'b1);                // redirect beats stall
        adv(3);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);                   // halt
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, i[1], i[0]);
        cycle(1'b1, 16'h0010, 1'b0, 1'b0);                // resume from halt
        adv(3);
        cycle(1'b1, 16'hFFFE, 1'b0, 1'b0);                // wrap-around
        adv(4);

        pulse_reset();
        adv(70);                                          // small instance faults at 63
        cycle(1'b1, 16'd5, 1'b0, 1'b0);
        adv(3);
        cycle(1'b1, 16'd100, 1'b0, 1'b0);
        adv(3);

        for (int i = 0; i < 1500; i++) begin
            logic        rv, hr, st;
            logic [15:0] rpc;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            rv = ($urandom_range(0, 7) == 0);
            hr = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       rpc = 16'($urandom);
                1:       rpc = 16'($urandom_range(65530, 65535));
                default: rpc = 16'($urandom_range(0, 90));
            endcase
            cycle(rv, rpc, hr, st);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drain", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
